// File: rtl/config_source_arbiter.sv
// Round-robin arbiter that grants one bitstream source at a time, buffers its words
// in a small FIFO and paces them onto the eFPGA self-write port.
module config_source_arbiter #(
  parameter int NUM_SOURCES  = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STROBE_GAP   = 0,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                              clk_system_i,
  input  logic                              reset_i,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_write_data_i,
  input  logic [NUM_SOURCES-1:0]            src_write_strobe_i,
  input  logic [NUM_SOURCES-1:0]            src_active_i,
  output logic [DATA_WIDTH-1:0]             efpga_write_data_o,
  output logic                              efpga_write_strobe_o,
  output logic                              boot_o,
  output logic [NUM_SOURCES-1:0]            grant_o,
  output logic [NUM_SOURCES-1:0]            dropped_o,
  output logic                              overflow_o
);

  localparam int PW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (STROBE_GAP > 0) ? $clog2(STROBE_GAP + 1) : 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(STROBE_GAP);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [NUM_SOURCES-1:0] grant_q, grant_d;
  logic [PW-1:0]          gidx_q, gidx_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                   boot_q, boot_d;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [IW-1:0]          idle_q, idle_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_strobe_q, out_strobe_d;
  logic [NUM_SOURCES-1:0] dropped_q, dropped_d;
  logic                   overflow_q, overflow_d;

  logic [NUM_SOURCES-1:0] request;
  logic [PW-1:0]          win_idx;
  logic [PW-1:0]          push_idx;
  logic                   push_req;
  logic                   push;
  logic                   pop;
  logic                   full;

  // First requester found searching upward (with wrap) from the start index.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_SOURCES-1:0] req,
                                            input logic [PW-1:0] start);
    logic [PW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      idx = (int'(start) + k) % NUM_SOURCES;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    return pick;
  endfunction

  always_comb begin
    request      = src_write_strobe_i | src_active_i;
    win_idx      = rr_pick(request, rr_ptr_q);
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_ptr_d     = rr_ptr_q;
    boot_d       = boot_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    gap_d        = gap_q;
    idle_d       = idle_q;
    out_data_d   = out_data_q;
    out_strobe_d = 1'b0;
    dropped_d    = dropped_q;
    overflow_d   = overflow_q;
    push_req     = 1'b0;
    push_idx     = gidx_q;
    full         = (count_q == FULL_COUNT);
    pop          = (count_q != '0) && (gap_q == '0) && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (|request) begin
          state_d          = GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = win_idx;
          boot_d           = 1'b1;
          idle_d           = '0;
          push_idx         = win_idx;
          push_req         = src_write_strobe_i[win_idx];
        end
      end
      GRANT: begin
        push_req = src_write_strobe_i[gidx_q];
        if (push_req) begin
          idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
          idle_d = idle_q + 1'b1;
        end
        if (!src_active_i[gidx_q] && (idle_q == IDLE_MAX)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((count_q == '0) && (gap_q == '0)) begin
          state_d  = IDLE;
          grant_d  = '0;
          boot_d   = 1'b0;
          rr_ptr_d = (gidx_q == PW'(NUM_SOURCES - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push = push_req && (!full || pop);
    if (push_req && full && !pop) begin
      overflow_d = 1'b1;
    end

    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (src_write_strobe_i[i] && !(push_req && (push_idx == PW'(i)))) begin
        dropped_d[i] = 1'b1;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = src_write_data_i[push_idx*DATA_WIDTH +: DATA_WIDTH];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      out_data_d   = mem_q[rd_ptr_q];
      out_strobe_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + 1'b1;
      gap_d        = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_system_i) begin
    mem_q <= mem_d;
    if (reset_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      rr_ptr_q     <= '0;
      boot_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      gap_q        <= '0;
      idle_q       <= '0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
      dropped_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      rr_ptr_q     <= rr_ptr_d;
      boot_q       <= boot_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      gap_q        <= gap_d;
      idle_q       <= idle_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
      dropped_q    <= dropped_d;
      overflow_q   <= overflow_d;
    end
  end

  assign efpga_write_data_o   = out_data_q;
  assign efpga_write_strobe_o = out_strobe_q;
  assign boot_o               = boot_q;
  assign grant_o              = grant_q;
  assign dropped_o            = dropped_q;
  assign overflow_o           = overflow_q;

endmodule
